alu_job_arbiter: RTL and testbench
==================================

# alu_job_arbiter

Shares a single ALU register-mapped slave among `N_REQ` requesters. Each job arrives on a req/ack port and is arbitrated round-robin. The block sequences the ALU writes (operand A, operand B, opcode), waits for the result, reads it back, and returns it to the winning requester. It sits between the processing clients and the ALU's Avalon-MM slave and is the only master on that slave.

## Interface

**Parameters**
- `N_REQ`, 4: number of requesters, 2..8.
- `WAIT_CYCLES`, 2: cycles between the opcode write and the result read, 1..15.

**Ports**
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req`  in  N_REQ: job request per requester; held high until the matching `req_ack`.
- `req_op_a`  in  16*N_REQ: operand A, requester i at [16i+15:16i].
- `req_op_b`  in  16*N_REQ: operand B, same packing.
- `req_opcode`  in  4*N_REQ: operation: 0 add, 1 sub, 2 mul, 3 div, 4 shl, 5 shr.
- `req_ack`  out  N_REQ: one-hot, one-cycle pulse; the job has been latched.
- `rsp_valid`  out  N_REQ: one-hot, one-cycle pulse; the response is valid.
- `rsp_data`  out  32: result; valid only while `rsp_valid` is nonzero.
- `rsp_err`  out  1: job rejected; valid with `rsp_valid`.
- `busy`  out  1: high whenever state is not IDLE.
- `avs_address`  out  3: ALU register address.
- `avs_write_data`  out  32: write data; upper bits are zero-filled.
- `avs_write`  out  1: write strobe.
- `avs_read`  out  1: read strobe.
- `avs_read_data`  in  32: ALU result; combinational; valid in the same cycle as `avs_read`.

## Operation

**ALU map**
- addr 0: operand A [15:0].
- addr 1: operand B [15:0].
- addr 2: opcode [3:0]. Writing it launches the operation.
- The result is readable from `WAIT_CYCLES` ≥ 1 cycles after the opcode write.

**States**
- IDLE → WR_A → WR_B → WR_OP → WAIT → RD → RSP → IDLE.
- Reject path: IDLE → REJ → RSP → IDLE.

**Arbitration**
- Sampled only in IDLE.
- Round-robin search starts at `last_grant+1` mod `N_REQ`.
- The winner's operands and opcode are latched into internal job registers; `last_grant` is updated to the winner.

**Per-state behaviour**
- WR_A: `avs_write`=1, addr 0, data `{16'h0, A}`.
- WR_B: `avs_write`=1, addr 1, data `{16'h0, B}`.
- WR_OP: `avs_write`=1, addr 2, data `{28'h0, opcode}`.
- WAIT: the counter loads `WAIT_CYCLES-1` and exits at 0.
- RD: `avs_read`=1; `avs_read_data` is captured into the result register at the end of the cycle.
- RSP: `rsp_valid[winner]`=1; `rsp_data` = captured result; `rsp_err`=0.

**Reject conditions**
- Opcode > 5, or opcode 3 with B = 0.
- The ALU is never accessed on the reject path.
- REJ emits only `req_ack`. RSP then emits `rsp_err`=1 and `rsp_data`=0.

**General rules**
- `avs_write` and `avs_read` are never high together. Both are 0 in IDLE, REJ, WAIT and RSP.
- `avs_address` and `avs_write_data` are 0 when no strobe is active.
- Requests arriving while busy are held by the requester. A requester may re-raise `req` right after its ack, but is arbitrated only in the next IDLE.
- After the ack, the latched job completes even if `req` or the operands change.

## Timing

- All outputs are registered.

**Reset**
- All outputs are 0, state is IDLE, the WAIT counter is 0.
- `last_grant` resets to `N_REQ-1`, so requester 0 has first priority.
- Reset asserted mid-job aborts it: no `rsp_valid` is issued and no further ALU access occurs.

**Valid job**, with `req[i]` sampled high at IDLE edge E0:
- `req_ack[i]` and WR_A occur in cycle 1 after E0.
- WR_B occurs in cycle 2, WR_OP in cycle 3.
- WAIT spans cycles 4..3+W.
- RD occurs in cycle 4+W.
- `rsp_valid[i]` occurs in cycle 5+W.
- IDLE is reached in cycle 6+W and can grant at that edge.
- Throughput is one job per W+6 cycles.

**Rejected job**
- `req_ack` in cycle 1; `rsp_valid` with `rsp_err` in cycle 2; IDLE in cycle 3.

## Test plan

1. **Single add:** requester 0, A=0xFFFF, B=0x0001, op 0, W=2 → `req_ack[0]` in cycle 1; writes to addr 0/1/2 in cycles 1/2/3; `avs_read` in cycle 6; `rsp_valid[0]` in cycle 7 with `rsp_data`=0x00010000 and `rsp_err`=0.
2. **Round-robin:** all 4 requesters raise `req` together and hold it until acked → grants 0,1,2,3 in order, each `rsp_valid` 8 cycles apart. Requester 0 re-raises immediately → its next grant comes after 3, not before 1.
3. **Rejects:** op 7 from requester 2; op 3 with B=0 from requester 1 → no `avs_write`/`avs_read` pulses; `rsp_valid` in cycle 2 with `rsp_err`=1 and `rsp_data`=0.
4. **Arithmetic readback:** mul 0x1234×0x0010 → 0x00012340. Sub 5−7 → 0x0001FFFE. Div 100/7 → 0x0000000E.
5. **Reset mid-job:** `rst_n` low for 1 cycle during WAIT → the next cycle has all outputs 0 and `busy`=0, and no `rsp_valid` follows. A new request on requester 0 is then granted first.
6. **Protocol checks:** random traffic, 1000 jobs → at most one `req_ack` bit and one `rsp_valid` bit high at a time; exactly one `rsp_valid` per `req_ack`; `avs_write` and `avs_read` never both high.

Source files
------------

// File: rtl/alu_job_arbiter_if.sv
// rtl/alu_job_arbiter_if.sv - Avalon-MM style ALU slave bus shared by the job arbiter
interface alu_job_arbiter_if;
    logic [2:0]  avs_address;
    logic [31:0] avs_write_data;
    logic        avs_write;
    logic        avs_read;
    logic [31:0] avs_read_data;

    modport master (
        output avs_address,
        output avs_write_data,
        output avs_write,
        output avs_read,
        input  avs_read_data
    );

    modport slave (
        input  avs_address,
        input  avs_write_data,
        input  avs_write,
        input  avs_read,
        output avs_read_data
    );
endinterface

// File: rtl/alu_job_arbiter.sv
// rtl/alu_job_arbiter.sv - round-robin job arbiter sequencing a shared register-mapped ALU
module alu_job_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   req_op_a,
    input  logic [16*N_REQ-1:0]   req_op_b,
    input  logic [4*N_REQ-1:0]    req_opcode,
    output logic [N_REQ-1:0]      req_ack,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    alu_job_arbiter_if.master     avs
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_OP, WAIT, RD, REJ, RSP} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic [15:0]      job_b;
    logic [3:0]       job_op;
    logic [3:0]       cnt;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [15:0]      grant_a;
    logic [15:0]      grant_b;
    logic [3:0]       grant_op;
    logic             grant_rej;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_a   = 16'(req_op_a >> (16 * grant_idx));
        grant_b   = 16'(req_op_b >> (16 * grant_idx));
        grant_op  = 4'(req_opcode >> (4 * grant_idx));
        grant_rej = (grant_op > 4'd5) || (grant_op == 4'd3 && grant_b == 16'h0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            last_grant         <= IDX_W'(N_REQ - 1);
            winner             <= '0;
            job_b              <= '0;
            job_op             <= '0;
            cnt                <= '0;
            req_ack            <= '0;
            rsp_valid          <= '0;
            rsp_data           <= '0;
            rsp_err            <= 1'b0;
            busy               <= 1'b0;
            avs.avs_address    <= '0;
            avs.avs_write_data <= '0;
            avs.avs_write      <= 1'b0;
            avs.avs_read       <= 1'b0;
        end else begin
            req_ack            <= '0;
            rsp_valid          <= '0;
            rsp_data           <= '0;
            rsp_err            <= 1'b0;
            avs.avs_address    <= '0;
            avs.avs_write_data <= '0;
            avs.avs_write      <= 1'b0;
            avs.avs_read       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        winner     <= grant_idx;
                        last_grant <= grant_idx;
                        job_b      <= grant_b;
                        job_op     <= grant_op;
                        req_ack    <= N_REQ'(1) << grant_idx;
                        busy       <= 1'b1;
                        if (grant_rej) begin
                            state <= REJ;
                        end else begin
                            state              <= WR_A;
                            avs.avs_write      <= 1'b1;
                            avs.avs_write_data <= {16'h0, grant_a};
                        end
                    end
                end
                WR_A: begin
                    state              <= WR_B;
                    avs.avs_write      <= 1'b1;
                    avs.avs_address    <= 3'd1;
                    avs.avs_write_data <= {16'h0, job_b};
                end
                WR_B: begin
                    state              <= WR_OP;
                    avs.avs_write      <= 1'b1;
                    avs.avs_address    <= 3'd2;
                    avs.avs_write_data <= {28'h0, job_op};
                end
                WR_OP: begin
                    state <= WAIT;
                    cnt   <= 4'(WAIT_CYCLES - 1);
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state           <= RD;
                        avs.avs_read    <= 1'b1;
                        avs.avs_address <= 3'd3;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD: begin
                    state     <= RSP;
                    rsp_valid <= N_REQ'(1) << winner;
                    rsp_data  <= avs.avs_read_data;
                end
                REJ: begin
                    state     <= RSP;
                    rsp_valid <= N_REQ'(1) << winner;
                    rsp_err   <= 1'b1;
                end
                RSP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_job_arbiter.sv
// tb/tb_alu_job_arbiter.sv - directed and random-traffic bench for alu_job_arbiter
module tb_alu_job_arbiter;
    localparam int N_REQ = 4;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic [15:0] opc = '0;
    logic [3:0]  req_ack;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    alu_job_arbiter_if avs_bus();

    alu_job_arbiter #(.N_REQ(N_REQ), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op_a(op_a), .req_op_b(op_b),
        .req_opcode(opc), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .avs(avs_bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] alu_a, alu_b;
    logic [31:0] alu_res;

    function automatic logic [31:0] alu_calc(input logic [15:0] a, b, input logic [3:0] op);
        case (op)
            4'd0: return 32'(a) + 32'(b);
            4'd1: return (32'(a) - 32'(b)) & 32'h0001_FFFF;
            4'd2: return 32'(a) * 32'(b);
            4'd3: return (b != 0) ? 32'(a / b) : 32'h0;
            4'd4: return 32'(a) << b[3:0];
            4'd5: return 32'(a) >> b[3:0];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (avs_bus.avs_write) begin
            case (avs_bus.avs_address)
                3'd0: alu_a <= avs_bus.avs_write_data[15:0];
                3'd1: alu_b <= avs_bus.avs_write_data[15:0];
                3'd2: alu_res <= alu_calc(alu_a, alu_b, avs_bus.avs_write_data[3:0]);
                default: ;
            endcase
        end
    end
    assign avs_bus.avs_read_data = avs_bus.avs_read ? alu_res : 32'h0;

    function automatic logic [127:0] mk(input logic [3:0] ack, rv, input logic err, bz, wr, rd,
                                        input logic [2:0] addr, input logic [31:0] wd, rdat);
        return 128'({ack, rv, err, bz, wr, rd, addr, wd, rdat});
    endfunction

    function automatic logic [127:0] snap();
        logic [2:0] addr;
        addr = avs_bus.avs_read ? 3'd0 : avs_bus.avs_address;
        return mk(req_ack, rsp_valid, rsp_err, busy, avs_bus.avs_write, avs_bus.avs_read,
                  addr, avs_bus.avs_write_data, rsp_data);
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [15:0] a, b, input logic [3:0] op);
        op_a[16*i +: 16] = a;
        op_b[16*i +: 16] = b;
        opc[4*i +: 4]    = op;
    endtask

    task automatic wait_for(input bit want_rsp, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (want_rsp ? (rsp_valid != 0) : (req_ack != 0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at a negedge while the DUT is idle; walks the job cycle by cycle.
    task automatic run_job(input int idx, input logic [15:0] a, b, input logic [3:0] op,
                           input logic [31:0] exp_data, input bit exp_err, input string tag);
        int n_last;
        logic [127:0] e;
        set_lane(idx, a, b, op);
        req[idx] = 1'b1;
        n_last = exp_err ? 3 : W + 6;
        for (int n = 1; n <= n_last; n++) begin
            @(negedge clk);
            e = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
            if (exp_err) begin
                if (n == 1) e = mk(onehot(idx), 0, 0, 1, 0, 0, 0, 0, 0);
                if (n == 2) e = mk(0, onehot(idx), 1, 1, 0, 0, 0, 0, 0);
                if (n == 3) e = '0;
            end else begin
                if (n == 1)     e = mk(onehot(idx), 0, 0, 1, 1, 0, 3'd0, {16'h0, a}, 0);
                if (n == 2)     e = mk(0, 0, 0, 1, 1, 0, 3'd1, {16'h0, b}, 0);
                if (n == 3)     e = mk(0, 0, 0, 1, 1, 0, 3'd2, {28'h0, op}, 0);
                if (n == 4 + W) e = mk(0, 0, 0, 1, 0, 1, 0, 0, 0);
                if (n == 5 + W) e = mk(0, onehot(idx), 0, 1, 0, 0, 0, 0, exp_data);
                if (n == 6 + W) e = '0;
            end
            check($sformatf("%s_c%0d", tag, n), snap(), e);
            if (n == 1) req[idx] = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int prev;
        int rr_order[5];
        int glitches;
        int done;
        int budget;
        logic [3:0] outstanding;
        bit pend_err;
        bit lane_err[4];
        logic [15:0] ra, rb;
        logic [3:0] rop;

        rr_order = '{0, 1, 2, 3, 0};
        repeat (3) @(negedge clk);
        check("reset", snap(), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round robin with requester 0 re-raising right after its grant
        for (int i = 0; i < 4; i++) set_lane(i, 16'(i), 16'h0010, 4'd0);
        req = 4'hF;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_for(1'b0, ok);
            check($sformatf("rr_ack%0d", k), {ok, req_ack}, {1'b1, onehot(rr_order[k])});
            if (k != 0) req[rr_order[k]] = 1'b0;
            wait_for(1'b1, ok);
            check($sformatf("rr_rsp%0d", k), {ok, rsp_valid, rsp_data},
                  {1'b1, onehot(rr_order[k]), 32'h10 + 32'(rr_order[k])});
            if (k > 0) check($sformatf("rr_gap%0d", k), 128'(cyc - prev), 128'(8));
            prev = cyc;
        end
        @(negedge clk);

        run_job(0, 16'hFFFF, 16'h0001, 4'd0, 32'h0001_0000, 1'b0, "add");
        run_job(2, 16'h1234, 16'h5678, 4'd7, 32'h0, 1'b1, "rej_op7");
        run_job(1, 16'h0005, 16'h0000, 4'd3, 32'h0, 1'b1, "rej_div0");
        run_job(0, 16'h1234, 16'h0010, 4'd2, 32'h0001_2340, 1'b0, "mul");
        run_job(1, 16'h0005, 16'h0007, 4'd1, 32'h0001_FFFE, 1'b0, "sub");
        run_job(3, 16'd100,  16'd7,    4'd3, 32'h0000_000E, 1'b0, "div");
        run_job(2, 16'h0003, 16'h0004, 4'd4, 32'h0000_0030, 1'b0, "shl");
        run_job(0, 16'h8000, 16'h000F, 4'd5, 32'h0000_0001, 1'b0, "shr");

        // Abort a job from requester 1 during WAIT
        set_lane(1, 16'h0001, 16'h0002, 4'd0);
        req[1] = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) req[1] = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid", snap(), '0);
        rst_n = 1'b1;
        glitches = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid != 0 || avs_bus.avs_write || avs_bus.avs_read || busy) glitches++;
        end
        check("rst_quiet", 128'(glitches), 128'(0));
        set_lane(0, 16'd7, 16'd8, 4'd0);
        set_lane(2, 16'd9, 16'd1, 4'd0);
        req = 4'b0101;
        wait_for(1'b0, ok);
        check("rst_ack0", {ok, req_ack}, {1'b1, 4'b0001});
        req[0] = 1'b0;
        wait_for(1'b1, ok);
        check("rst_rsp0", {ok, rsp_valid, rsp_data}, {1'b1, 4'b0001, 32'd15});
        wait_for(1'b0, ok);
        check("rst_ack2", {ok, req_ack}, {1'b1, 4'b0100});
        req[2] = 1'b0;
        wait_for(1'b1, ok);
        check("rst_rsp2", {ok, rsp_valid, rsp_data}, {1'b1, 4'b0100, 32'd10});
        @(negedge clk);

        // Random traffic: requesters hold req until acked, then may re-raise at once
        done = 0;
        budget = 0;
        outstanding = '0;
        pend_err = 1'b0;
        for (int i = 0; i < 4; i++) lane_err[i] = 1'b0;
        while (done < 1000 && budget < 20000) begin
            @(negedge clk);
            budget++;
            check("proto", 128'({$onehot0(req_ack), $onehot0(rsp_valid),
                                 !(avs_bus.avs_write && avs_bus.avs_read)}), 128'(3'b111));
            if (req_ack != 0) begin
                check("rand_ack_single", 128'(outstanding), 128'(0));
                outstanding = req_ack;
                for (int i = 0; i < 4; i++) if (req_ack[i]) begin
                    req[i] = 1'b0;
                    pend_err = lane_err[i];
                end
            end
            if (rsp_valid != 0) begin
                check("rand_rsp", 128'({rsp_valid, rsp_err}), 128'({outstanding, pend_err}));
                outstanding = '0;
                done++;
            end
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    ra  = 16'($urandom);
                    rb  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                    rop = 4'($urandom_range(0, 7));
                    set_lane(i, ra, rb, rop);
                    lane_err[i] = (rop > 4'd5) || (rop == 4'd3 && rb == 16'h0);
                    req[i] = 1'b1;
                end
            end
        end
        check("rand_done", 128'(done), 128'(1000));
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
